memory_to_dram: RTL and testbench

Read-back path from on-chip BRAM to DRAM, in the opposite direction to the DRAM-to-memory packer. On start, the block reads a programmed number of wide memory words from consecutive BRAM addresses. It splits each word into narrow DRAM beats, most-significant first, using the same bit alignment as the packer: the memory word is left-aligned and zero-padded at the LSB end. Beats go out on a valid/ready stream toward the DRAM write interface.

---
 rtl/memory_to_dram.sv | 137 +++++++++++++
 tb/tb_memory_to_dram.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_to_dram.sv
// memory_to_dram: reads a programmed run of wide BRAM words and emits each
// one as a sequence of narrow DRAM beats on a valid/ready stream, most
// significant beat first. The BRAM word is left-aligned and zero-padded at
// the LSB end, which matches the alignment used by the DRAM-to-memory packer.
module memory_to_dram #(
  parameter int DATA_IN_BITWIDTH  = 163,
  parameter int DATA_OUT_BITWIDTH = 32,
  parameter int ADDR_BITWIDTH     = 10
) (
  input  logic                         clk_i,
  input  logic                         mem_to_dram_rst_i,
  input  logic                         start_i,
  input  logic [ADDR_BITWIDTH-1:0]     base_addr_i,
  input  logic [ADDR_BITWIDTH:0]       num_words_i,
  output logic [ADDR_BITWIDTH-1:0]     mem_addr_o,
  output logic                         mem_read_enable_o,
  input  logic [DATA_IN_BITWIDTH-1:0]  mem_data_i,
  output logic [DATA_OUT_BITWIDTH-1:0] data_out_o,
  output logic                         data_valid_o,
  input  logic                         dram_ready_i,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int BEATS             = (DATA_IN_BITWIDTH + DATA_OUT_BITWIDTH - 1) / DATA_OUT_BITWIDTH;
  localparam int PAD_BITWIDTH      = BEATS * DATA_OUT_BITWIDTH;
  localparam int BEAT_CNT_BITWIDTH = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_CNT_BITWIDTH-1:0] LAST_BEAT = BEAT_CNT_BITWIDTH'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_SEND,
    S_DONE
  } state_t;

  state_t                         r_state;
  state_t                         w_next_state;
  logic [PAD_BITWIDTH-1:0]        r_shift;
  logic [BEAT_CNT_BITWIDTH-1:0]   r_beat;
  logic [ADDR_BITWIDTH:0]         r_words;
  logic [ADDR_BITWIDTH-1:0]       r_addr;

  logic                           w_start_accept;
  logic                           w_beat_accept;
  logic                           w_last_beat;
  logic [PAD_BITWIDTH-1:0]        w_load;

  assign w_start_accept = (r_state == S_IDLE) && start_i;
  assign w_beat_accept  = (r_state == S_SEND) && dram_ready_i;
  assign w_last_beat    = w_beat_accept && (r_beat == LAST_BEAT);

  // Left-align the BRAM word inside the beat-multiple frame; the shift form
  // stays legal when the word already fills the frame exactly (zero padding).
  assign w_load = PAD_BITWIDTH'(mem_data_i) << (PAD_BITWIDTH - DATA_IN_BITWIDTH);

  // State register.
  always_ff @(posedge clk_i or posedge mem_to_dram_rst_i) begin
    if (mem_to_dram_rst_i) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignment so every register
      // samples the pre-edge values of the others, whatever the block order.
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    // NOTE: the default assignment up front keeps every path assigned, so no
    // latch is inferred when a case branch leaves the state unchanged.
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_next_state = (num_words_i == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH:   w_next_state = S_CAPTURE;
      S_CAPTURE: w_next_state = S_SEND;
      S_SEND: begin
        if (w_last_beat) begin
          w_next_state = (r_words != '0) ? S_FETCH : S_DONE;
        end
      end
      S_DONE:    w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Datapath: transfer parameters, address/word counters, beat shifter.
  always_ff @(posedge clk_i or posedge mem_to_dram_rst_i) begin
    if (mem_to_dram_rst_i) begin
      r_shift <= '0;
      r_beat  <= '0;
      r_words <= '0;
      r_addr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_accept) begin
            r_addr  <= base_addr_i;
            r_words <= num_words_i;
          end
        end
        S_CAPTURE: begin
          // BRAM data for the address issued in FETCH is valid this cycle.
          r_shift <= w_load;
          r_beat  <= '0;
          r_words <= r_words - 1'b1;
          r_addr  <= r_addr + 1'b1;
        end
        S_SEND: begin
          if (w_beat_accept) begin
            r_shift <= r_shift << DATA_OUT_BITWIDTH;
            r_beat  <= r_beat + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs come straight from registers (state and shifter), so they are
  // glitch-free and fall to zero as soon as reset is asserted. The shifter
  // is fully drained after the last beat, so data_out_o reads zero whenever
  // no beat is presented.
  assign mem_addr_o        = r_addr;
  assign mem_read_enable_o = (r_state == S_FETCH);
  assign data_out_o        = r_shift[PAD_BITWIDTH-1 -: DATA_OUT_BITWIDTH];
  assign data_valid_o      = (r_state == S_SEND);
  assign busy_o            = (r_state != S_IDLE);
  assign done_o            = (r_state == S_DONE);

endmodule

// File: tb/tb_memory_to_dram.sv
// Self-checking bench for memory_to_dram: table of transfers plus hand-written
// backpressure, busy-start and mid-transfer reset sequences. Expected BRAM
// addresses and DRAM beats are queued when a transfer is launched and
// popped by a negedge monitor as the DUT produces them.
module tb_memory_to_dram;

  localparam int DIN   = 163;
  localparam int DOUT  = 32;
  localparam int AW    = 10;
  localparam int NBEAT = 6;

  logic            clk_i = 1'b0;
  logic            mem_to_dram_rst_i = 1'b1;
  logic            start_i = 1'b0;
  logic [AW-1:0]   base_addr_i = '0;
  logic [AW:0]     num_words_i = '0;
  logic [AW-1:0]   mem_addr_o;
  logic            mem_read_enable_o;
  logic [DIN-1:0]  mem_data_i;
  logic [DOUT-1:0] data_out_o;
  logic            data_valid_o;
  logic            dram_ready_i = 1'b1;
  logic            busy_o;
  logic            done_o;

  memory_to_dram #(
    .DATA_IN_BITWIDTH (DIN),
    .DATA_OUT_BITWIDTH(DOUT),
    .ADDR_BITWIDTH    (AW)
  ) dut (
    .clk_i            (clk_i),
    .mem_to_dram_rst_i(mem_to_dram_rst_i),
    .start_i          (start_i),
    .base_addr_i      (base_addr_i),
    .num_words_i      (num_words_i),
    .mem_addr_o       (mem_addr_o),
    .mem_read_enable_o(mem_read_enable_o),
    .mem_data_i       (mem_data_i),
    .data_out_o       (data_out_o),
    .data_valid_o     (data_valid_o),
    .dram_ready_i     (dram_ready_i),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Cycle index: during the cycle following posedge n, cyc == n.
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // BRAM model with one cycle of read latency.
  logic [DIN-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk_i) begin
    if (mem_read_enable_o) mem_data_i <= mem[mem_addr_o];
  end

  // Ready driver: 0 = always ready, 1 = random, 2 = scripted by the test.
  int   ready_mode = 0;
  logic scripted_ready = 1'b1;
  always @(posedge clk_i) begin
    #1;
    if (ready_mode == 0)      dram_ready_i = 1'b1;
    else if (ready_mode == 1) dram_ready_i = 1'($urandom_range(0, 1));
    else                      dram_ready_i = scripted_ready;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard queues.
  logic [AW-1:0]   exp_addr_q[$];
  logic [DOUT-1:0] exp_beat_q[$];

  // Per-transfer observations.
  int        t_start;
  int        beats, reads, done_cnt, stalls;
  int        first_rd, first_valid, done_cyc, last_valid, gap_min, gap_max;
  logic [DOUT-1:0] first_beat_data, last_beat_data, prev_data;
  bit        prev_stall;

  task automatic clear_stats();
    beats = 0; reads = 0; done_cnt = 0; stalls = 0;
    first_rd = -1; first_valid = -1; done_cyc = -1; last_valid = -1;
    gap_min = 999; gap_max = -1; prev_stall = 1'b0;
    first_beat_data = '0; last_beat_data = '0; prev_data = '0;
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk_i) begin
    if (!mem_to_dram_rst_i) begin
      if (mem_read_enable_o) begin
        reads++;
        if (first_rd < 0) first_rd = cyc;
        if (exp_addr_q.size() == 0) check("unexpected_read", 64'(mem_addr_o), 64'hFFFF);
        else check("read_addr", 64'(mem_addr_o), 64'(exp_addr_q.pop_front()));
      end
      if (data_valid_o) begin
        if (first_valid < 0) first_valid = cyc;
        if (last_valid >= 0 && cyc - last_valid > 1) begin
          if (cyc - last_valid - 1 < gap_min) gap_min = cyc - last_valid - 1;
          if (cyc - last_valid - 1 > gap_max) gap_max = cyc - last_valid - 1;
        end
        last_valid = cyc;
        if (prev_stall) check("stall_hold_data", 64'(data_out_o), 64'(prev_data));
        if (dram_ready_i) begin
          if (beats == 0) first_beat_data = data_out_o;
          beats++;
          last_beat_data = data_out_o;
          if (exp_beat_q.size() == 0) check("unexpected_beat", 64'(data_out_o), 64'hFFFF_FFFF_FFFF);
          else check("beat_data", 64'(data_out_o), 64'(exp_beat_q.pop_front()));
          prev_stall = 1'b0;
        end else begin
          stalls++;
          prev_stall = 1'b1;
          prev_data  = data_out_o;
        end
      end else if (prev_stall) begin
        check("stall_hold_valid", 64'(data_valid_o), 64'd1);
        prev_stall = 1'b0;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
        check("valid_low_in_done", 64'(data_valid_o), 64'd0);
      end
    end
  end

  // Reference split: beat k = padded[191-32k -: 32], padded = {word, 29'b0}.
  function automatic logic [DOUT-1:0] model_beat(input logic [DIN-1:0] w, input int k);
    logic [NBEAT*DOUT-1:0] padded;
    padded = {w, {(NBEAT*DOUT-DIN){1'b0}}};
    return padded[NBEAT*DOUT-1-DOUT*k -: DOUT];
  endfunction

  task automatic fill(input logic [AW-1:0] b, input logic [AW:0] n, input int pat);
    logic [AW-1:0] a;
    logic [NBEAT*DOUT-1:0] r;
    for (int i = 0; i < int'(n); i++) begin
      a = b + AW'(i);
      r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      case (pat)
        0:       mem[a] = {32'hDEAD_BEEF, {(DIN-32){1'b0}}};
        1:       mem[a] = {DIN{1'b1}};
        default: mem[a] = r[DIN-1:0];
      endcase
    end
  endtask

  task automatic push_expect(input logic [AW-1:0] b, input logic [AW:0] n);
    logic [AW-1:0] a;
    for (int i = 0; i < int'(n); i++) begin
      a = b + AW'(i);
      exp_addr_q.push_back(a);
      for (int k = 0; k < NBEAT; k++) exp_beat_q.push_back(model_beat(mem[a], k));
    end
  endtask

  task automatic start_transfer(input logic [AW-1:0] b, input logic [AW:0] n);
    @(posedge clk_i); #1;
    base_addr_i = b; num_words_i = n; start_i = 1'b1;
    t_start = cyc;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(negedge clk_i);
      k++;
    end
    check("done_timeout", 64'(done_cnt > 0), 64'd1);
    @(negedge clk_i);
    check("busy_after_done", 64'(busy_o), 64'd0);
    check("done_single_pulse", 64'(done_o), 64'd0);
  endtask

  task automatic wait_valid(input int budget);
    int k;
    k = 0;
    @(negedge clk_i);
    while (!data_valid_o && k < budget) begin
      @(negedge clk_i);
      k++;
    end
    check("valid_timeout", 64'(data_valid_o), 64'd1);
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   num;
    int            pat;
    int            mode;
    int            exp_beats;
    int            exp_done_lat;  // -1 when ready is random
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{base: 10'd5,    num: 11'd1, pat: 0, mode: 0, exp_beats: 6,  exp_done_lat: 9};
    vecs[1] = '{base: 10'd100,  num: 11'd1, pat: 1, mode: 0, exp_beats: 6,  exp_done_lat: 9};
    vecs[2] = '{base: 10'd1022, num: 11'd3, pat: 2, mode: 0, exp_beats: 18, exp_done_lat: 25};
    vecs[3] = '{base: 10'd0,    num: 11'd0, pat: 2, mode: 0, exp_beats: 0,  exp_done_lat: 1};
    vecs[4] = '{base: 10'd300,  num: 11'd4, pat: 2, mode: 1, exp_beats: 24, exp_done_lat: -1};
    vecs[5] = '{base: 10'd1023, num: 11'd2, pat: 2, mode: 1, exp_beats: 12, exp_done_lat: -1};

    clear_stats();

    // Reset state.
    #12;
    check("rst_valid", 64'(data_valid_o), 64'd0);
    check("rst_data",  64'(data_out_o),   64'd0);
    check("rst_busy",  64'(busy_o),       64'd0);
    check("rst_done",  64'(done_o),       64'd0);
    check("rst_rden",  64'(mem_read_enable_o), 64'd0);
    check("rst_addr",  64'(mem_addr_o),   64'd0);
    @(negedge clk_i);
    mem_to_dram_rst_i = 1'b0;

    // Table-driven transfers.
    for (int i = 0; i < 6; i++) begin
      ready_mode = vecs[i].mode;
      fill(vecs[i].base, vecs[i].num, vecs[i].pat);
      clear_stats();
      push_expect(vecs[i].base, vecs[i].num);
      start_transfer(vecs[i].base, vecs[i].num);
      wait_done(400);
      check("beat_count", 64'(beats), 64'(vecs[i].exp_beats));
      check("read_count", 64'(reads), 64'(vecs[i].num));
      check("done_count", 64'(done_cnt), 64'd1);
      check("beat_q_empty", 64'(exp_beat_q.size()), 64'd0);
      check("addr_q_empty", 64'(exp_addr_q.size()), 64'd0);
      if (vecs[i].num != 0) begin
        check("read_latency",  64'(first_rd - t_start), 64'd1);
        check("valid_latency", 64'(first_valid - t_start), 64'd3);
      end
      if (vecs[i].num > 1) begin
        check("word_gap_min", 64'(gap_min), 64'd2);
        check("word_gap_max", 64'(gap_max), 64'd2);
      end
      if (vecs[i].exp_done_lat >= 0)
        check("done_latency", 64'(done_cyc - t_start), 64'(vecs[i].exp_done_lat));
      if (i == 0) check("first_beat_deadbeef", 64'(first_beat_data), 64'hDEAD_BEEF);
      if (i == 1) check("last_beat_e0000000", 64'(last_beat_data), 64'hE000_0000);
      exp_beat_q.delete();
      exp_addr_q.delete();
    end

    // Backpressure: ready low for 3 cycles while beat 2 is presented.
    ready_mode = 2;
    scripted_ready = 1'b1;
    fill(10'd50, 11'd1, 1);
    clear_stats();
    push_expect(10'd50, 11'd1);
    start_transfer(10'd50, 11'd1);
    wait_valid(20);               // cycle F, beat 0
    @(negedge clk_i);             // cycle F+1, beat 1
    scripted_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk_i);           // cycles F+2..F+4, beat 2 stalled
      check("bp_valid", 64'(data_valid_o), 64'd1);
      check("bp_data",  64'(data_out_o),   64'hFFFF_FFFF);
    end
    scripted_ready = 1'b1;
    @(negedge clk_i);             // cycle F+5, beat 2 accepted
    check("bp_valid", 64'(data_valid_o), 64'd1);
    check("bp_data",  64'(data_out_o),   64'hFFFF_FFFF);
    wait_done(50);
    check("bp_stalls", 64'(stalls), 64'd3);
    check("bp_beat_count", 64'(beats), 64'd6);
    check("bp_done_latency", 64'(done_cyc - t_start), 64'd12);
    check("bp_beat_q_empty", 64'(exp_beat_q.size()), 64'd0);
    exp_beat_q.delete();
    exp_addr_q.delete();

    // Start pulse during SEND of a two-word transfer is ignored.
    ready_mode = 0;
    fill(10'd400, 11'd2, 2);
    clear_stats();
    push_expect(10'd400, 11'd2);
    start_transfer(10'd400, 11'd2);
    wait_valid(20);
    @(posedge clk_i); #1;
    base_addr_i = 10'd7; num_words_i = 11'd5; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    wait_done(100);
    check("busy_start_beats", 64'(beats), 64'd12);
    check("busy_start_reads", 64'(reads), 64'd2);
    check("busy_start_done",  64'(done_cnt), 64'd1);
    check("busy_start_q_empty", 64'(exp_beat_q.size()), 64'd0);
    repeat (3) @(negedge clk_i);
    check("busy_start_no_restart", 64'(busy_o), 64'd0);
    exp_beat_q.delete();
    exp_addr_q.delete();

    // Asynchronous reset while beat 3 is presented.
    fill(10'd200, 11'd2, 2);
    clear_stats();
    push_expect(10'd200, 11'd2);
    start_transfer(10'd200, 11'd2);
    wait_valid(20);               // cycle F, beat 0
    repeat (3) @(posedge clk_i);  // start of cycle F+3, beat 3
    #2;
    mem_to_dram_rst_i = 1'b1;
    #1;
    check("arst_valid", 64'(data_valid_o), 64'd0);
    check("arst_data",  64'(data_out_o),   64'd0);
    check("arst_busy",  64'(busy_o),       64'd0);
    check("arst_done",  64'(done_o),       64'd0);
    check("arst_rden",  64'(mem_read_enable_o), 64'd0);
    check("arst_addr",  64'(mem_addr_o),   64'd0);
    check("arst_beats_before", 64'(beats), 64'd3);
    exp_beat_q.delete();
    exp_addr_q.delete();
    @(negedge clk_i);
    mem_to_dram_rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("arst_no_done", 64'(done_cnt), 64'd0);
    check("arst_idle", 64'(busy_o), 64'd0);

    // Clean transfer after reset starts from beat 0.
    fill(10'd600, 11'd1, 2);
    clear_stats();
    push_expect(10'd600, 11'd1);
    start_transfer(10'd600, 11'd1);
    wait_done(50);
    check("post_rst_beats", 64'(beats), 64'd6);
    check("post_rst_valid_latency", 64'(first_valid - t_start), 64'd3);
    check("post_rst_done_latency", 64'(done_cyc - t_start), 64'd9);
    check("post_rst_q_empty", 64'(exp_beat_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
